// File: rtl/main_control_fsm_pkg.sv
// Shared opcodes, select codes, FSM state type and control word for the multicycle MIPS main controller.
package mips_ctrl_pkg;

  localparam int state_width = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [state_width-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    BNEEX   = 4'd12
  } ctrl_state_t;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
  } ctrl_word_t;

endpackage

// File: rtl/main_control_fsm_if.sv
// Controller <-> datapath signal bundle; master is the controller, slave is the datapath.
interface main_control_fsm_if #(
  parameter int op_width    = 6,
  parameter int ALUOp_width = 2
);
  logic [op_width-1:0]    Op;
  logic                   Zero;
  logic                   IorD;
  logic                   MemWrite;
  logic                   IRWrite;
  logic                   RegDst;
  logic                   MemtoReg;
  logic                   RegWrite;
  logic                   ALUSrcA;
  logic [1:0]             ALUSrcB;
  logic [ALUOp_width-1:0] ALUOp;
  logic [1:0]             PCSrc;
  logic                   PCEn;
  logic                   IllegalOp;

  modport master (
    input  Op, Zero,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, IllegalOp
  );

  modport slave (
    output Op, Zero,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, IllegalOp
  );
endinterface

// File: rtl/main_ctrl_output_decode.sv
// Moore output decoder: maps the current controller state to the datapath control word.
module main_ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  ctrl_state_t state,
  output ctrl_word_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.pc_write  = 1'b1;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMRD: ctrl.iord = 1'b1;
      MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      RTYPEEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      BEQEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
`ifdef MAIN_CTRL_BNE_EN
      BNEEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch_ne = 1'b1;
      end
`endif
      ADDIWB: ctrl.reg_write = 1'b1;
      JEX: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      // Unreachable encodings (and BNEEX when bne is disabled) leave everything at 0.
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main controller: state register, next-state logic, PCEn and reset gating.
// Optional bne support is enabled by defining MAIN_CTRL_BNE_EN.
module main_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  main_control_fsm_if.master bus
);

  ctrl_state_t state_q, state_d;
  ctrl_word_t  word;
  ctrl_word_t  word_out;
  logic        illegal_op;
  logic        pc_en;

  main_ctrl_output_decode u_decode (
    .state (state_q),
    .ctrl  (word)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = FETCH;
    illegal_op = 1'b0;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
`ifdef MAIN_CTRL_BNE_EN
          OP_BNE:       state_d = BNEEX;
`endif
          default: begin
            illegal_op = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      // Op is still held by IR here, so it picks load versus store.
      MEMADR:  state_d = (bus.Op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    word_out = word;
    pc_en    = word.pc_write | (word.branch & bus.Zero) | (word.branch_ne & ~bus.Zero);
    if (reset) begin
      // Abandon any instruction in flight: no writes, PC+4 selects presented.
      word_out           = '0;
      word_out.alu_src_b = SRCB_FOUR;
      pc_en              = 1'b0;
    end
  end

  assign bus.IorD      = word_out.iord;
  assign bus.MemWrite  = word_out.mem_write;
  assign bus.IRWrite   = word_out.ir_write;
  assign bus.RegDst    = word_out.reg_dst;
  assign bus.MemtoReg  = word_out.mem_to_reg;
  assign bus.RegWrite  = word_out.reg_write;
  assign bus.ALUSrcA   = word_out.alu_src_a;
  assign bus.ALUSrcB   = word_out.alu_src_b;
  assign bus.ALUOp     = word_out.alu_op;
  assign bus.PCSrc     = word_out.pc_src;
  assign bus.PCEn      = pc_en;
  assign bus.IllegalOp = illegal_op & ~reset;

endmodule

// File: tb/tb_main_control_fsm.sv
// Randomized scoreboard bench for main_control_fsm: an instruction-level model queues per-cycle control words.
module tb_main_control_fsm;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       illegal;
  } exp_t;

  typedef enum int {K_LW, K_SW, K_R, K_ADDI, K_BEQ, K_BNE, K_J, K_ILL} kind_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [5:0] op_q[$];

  main_control_fsm_if bus ();

  main_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic kind_t classify(input logic [5:0] op);
    case (op)
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000000: return K_R;
      6'b001000: return K_ADDI;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
`ifdef MAIN_CTRL_BNE_EN
      6'b000101: return K_BNE;
`endif
      default:   return K_ILL;
    endcase
  endfunction

  function automatic int latency(input kind_t k);
    case (k)
      K_LW:                return 5;
      K_SW, K_R, K_ADDI:   return 4;
      K_BEQ, K_BNE, K_J:   return 3;
      default:             return 2;
    endcase
  endfunction

  function automatic exp_t reset_word();
    exp_t e = '0;
    e.alu_src_b = 2'b01;
    return e;
  endfunction

  // Expected outputs for step s (0 = fetch) of an instruction of kind k, given Zero in that cycle.
  function automatic exp_t model(input kind_t k, input int s, input logic zero);
    exp_t e = '0;
    if (s == 0) begin
      e.ir_write = 1'b1; e.alu_src_b = 2'b01; e.pc_en = 1'b1;
    end else if (s == 1) begin
      e.alu_src_b = 2'b11; e.illegal = (k == K_ILL);
    end else begin
      case (k)
        K_LW, K_SW: begin
          if (s == 2) begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
          else if (s == 3) begin e.iord = 1'b1; e.mem_write = (k == K_SW); end
          else begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
        end
        K_R: begin
          if (s == 2) begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
          else begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
        end
        K_ADDI: begin
          if (s == 2) begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
          else e.reg_write = 1'b1;
        end
        K_BEQ, K_BNE: begin
          e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01;
          e.pc_en = (k == K_BEQ) ? zero : ~zero;
        end
        K_J: begin
          e.pc_src = 2'b10; e.pc_en = 1'b1;
        end
        default: e = '0;
      endcase
    end
    return e;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // zmode: 0/1 forces Zero, 2 randomizes it every cycle. abort_at>0 asserts reset in that step.
  task automatic run_instr(input logic [5:0] op, input int zmode, input int abort_at);
    kind_t k = classify(op);
    int    n = latency(k);
    bus.Op = op;
    for (int s = 0; s < n; s++) begin
      bus.Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      if (abort_at > 0 && s == abort_at) begin
        reset = 1'b1;
        exp_q.push_back(reset_word());
        op_q.push_back(op);
        next_cycle();
        reset = 1'b0;
        $display("instr op=%b kind=%s aborted by reset at step %0d", op, k.name(), s);
        return;
      end
      exp_q.push_back(model(k, s, bus.Zero));
      op_q.push_back(op);
      next_cycle();
    end
    $display("instr op=%b kind=%s cycles=%0d", op, k.name(), n);
  endtask

  // Monitor: one control word is presented every cycle; compare at the falling edge.
  initial begin
    exp_t e;
    exp_t act;
    logic [5:0] op;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        op = op_q.pop_front();
        act = {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite,
               bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSrc, bus.PCEn, bus.IllegalOp};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL ctrl_word t=%0t op=%b got=%h expected=%h", $time, op, act, e);
        end
      end
    end
  end

  initial begin
    logic [5:0] ops [8];
    logic [5:0] op;
    int abort;
    ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000; ops[3] = 6'b001000;
    ops[4] = 6'b000100; ops[5] = 6'b000010; ops[6] = 6'b000101; ops[7] = 6'b111111;

    reset = 1'b1;
    bus.Op = 6'b100011;
    bus.Zero = 1'b0;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(reset_word());
      op_q.push_back(bus.Op);
      next_cycle();
    end
    reset = 1'b0;
    $display("reset held 3 cycles");

    run_instr(6'b100011, 2, 0);
    run_instr(6'b101011, 2, 0);
    run_instr(6'b000000, 2, 0);
    run_instr(6'b001000, 2, 0);
    run_instr(6'b000100, 1, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 2, 0);
    run_instr(6'b111111, 2, 0);
    run_instr(6'b100011, 2, 3);
    run_instr(6'b000101, 1, 0);
    run_instr(6'b000101, 0, 0);

    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      abort = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0;
      run_instr(op, 2, abort);
    end

    repeat (3) next_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
